// File: rtl/ntt_pkg.sv
// Shared types and modular helpers for the NTT butterfly datapath.
package ntt_pkg;

  typedef enum logic [1:0] {
    BF_DIT    = 2'b00,
    BF_GS     = 2'b01,
    BF_MUL    = 2'b10,
    BF_BYPASS = 2'b11
  } bf_mode_t;

  localparam int LAT_MIN = 2;
  localparam int LAT_MAX = 8;

  // Helpers work on a fixed wide word; lanes zero-extend WIDTH+1-bit values into it.
  localparam int MOD_W = 64;
  typedef logic [MOD_W:0] mod_word_t;

  function automatic mod_word_t mod_add(input mod_word_t a, input mod_word_t b,
                                        input mod_word_t q);
    mod_word_t s;
    s = a + b;
    if (s >= q) begin
      mod_add = s - q;
    end else begin
      mod_add = s;
    end
  endfunction

  function automatic mod_word_t mod_sub(input mod_word_t a, input mod_word_t b,
                                        input mod_word_t q);
    if (a >= b) begin
      mod_sub = a - b;
    end else begin
      mod_sub = a + q - b;
    end
  endfunction

endpackage

// File: rtl/butterfly_array_pipe_lane.sv
// One butterfly lane: input capture, single-cycle modular compute, then LAT-2 delay stages.
module mod_bf_lane
  import ntt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LAT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  bf_mode_t         mode,
  input  logic             swap,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out
);

  logic [WIDTH-1:0]   a_r, b_r, w_r, q_r;
  bf_mode_t           mode_r;
  logic               swap_r;
  logic [WIDTH-1:0]   q_safe_s, sum_s, diff_s, mul_in_s, t_s, a_res_s, b_res_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   a_pipe_r [LAT-1];
  logic [WIDTH-1:0]   b_pipe_r [LAT-1];

  // Capture the operands and per-transaction controls at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      w_r    <= {WIDTH{1'b0}};
      q_r    <= {WIDTH{1'b0}};
      mode_r <= BF_DIT;
      swap_r <= 1'b0;
    end else if (en) begin
      a_r    <= a;
      b_r    <= b;
      w_r    <= w;
      q_r    <= q;
      mode_r <= mode;
      swap_r <= swap;
    end
  end

  // A zero modulus only appears in bubbles after reset; keep the reducer defined there.
  assign q_safe_s = (q_r == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : q_r;
  assign sum_s    = WIDTH'(mod_add(mod_word_t'(a_r), mod_word_t'(b_r), mod_word_t'(q_safe_s)));
  assign diff_s   = WIDTH'(mod_sub(mod_word_t'(a_r), mod_word_t'(b_r), mod_word_t'(q_safe_s)));

  // Select which operand feeds the twiddle multiplier.
  always_comb begin
    mul_in_s = b_r;
    case (mode_r)
      BF_GS:   mul_in_s = diff_s;
      BF_MUL: begin
        if (swap_r) begin
          mul_in_s = a_r;
        end else begin
          mul_in_s = b_r;
        end
      end
      default: mul_in_s = b_r;
    endcase
  end

  assign prod_s = (2*WIDTH)'(w_r) * (2*WIDTH)'(mul_in_s);
  assign t_s    = WIDTH'(prod_s % (2*WIDTH)'(q_safe_s));

  // Final per-mode combination of the reduced product with the operands.
  always_comb begin
    a_res_s = a_r;
    b_res_s = b_r;
    case (mode_r)
      BF_DIT: begin
        a_res_s = WIDTH'(mod_add(mod_word_t'(a_r), mod_word_t'(t_s), mod_word_t'(q_safe_s)));
        b_res_s = WIDTH'(mod_sub(mod_word_t'(a_r), mod_word_t'(t_s), mod_word_t'(q_safe_s)));
      end
      BF_GS: begin
        a_res_s = sum_s;
        b_res_s = t_s;
      end
      BF_MUL: begin
        if (swap_r) begin
          a_res_s = t_s;
          b_res_s = b_r;
        end else begin
          a_res_s = a_r;
          b_res_s = t_s;
        end
      end
      BF_BYPASS: begin
        a_res_s = a_r;
        b_res_s = b_r;
      end
      default: begin
        a_res_s = a_r;
        b_res_s = b_r;
      end
    endcase
  end

  // Result register followed by delay stages; the last stage drives the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT-1; i++) begin
        a_pipe_r[i] <= {WIDTH{1'b0}};
        b_pipe_r[i] <= {WIDTH{1'b0}};
      end
    end else if (en) begin
      a_pipe_r[0] <= a_res_s;
      b_pipe_r[0] <= b_res_s;
      for (int i = 1; i < LAT-1; i++) begin
        a_pipe_r[i] <= a_pipe_r[i-1];
        b_pipe_r[i] <= b_pipe_r[i-1];
      end
    end
  end

  assign a_out = a_pipe_r[LAT-2];
  assign b_out = b_pipe_r[LAT-2];

endmodule

// File: rtl/butterfly_array_pipe.sv
// SIZE lockstep modular butterfly lanes behind a valid/ready handshake with whole-pipe stall.
module butterfly_array_pipe
  import ntt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 128,
  parameter int LAT   = 4,
  parameter int TAG_W = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  bf_mode_t                    mode,
  input  logic                        swap,
  input  logic [TAG_W-1:0]            tag,
  input  logic [SIZE-1:0][WIDTH-1:0]  A,
  input  logic [SIZE-1:0][WIDTH-1:0]  B,
  input  logic [SIZE-1:0][WIDTH-1:0]  W,
  input  logic [WIDTH-1:0]            modulus,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TAG_W-1:0]            out_tag,
  output logic [SIZE-1:0][WIDTH-1:0]  A_out,
  output logic [SIZE-1:0][WIDTH-1:0]  B_out,
  output logic                        busy
);

  logic             en_s;
  logic [LAT-1:0]   valid_r;
  logic [TAG_W-1:0] tag_r [LAT];

  // The only thing that can stop the pipe is a presented result not being taken.
  assign en_s     = !(out_valid && !out_ready);
  assign in_ready = en_s;

  // Valid and tag chain mirrors the lane data stages one-for-one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        tag_r[i] <= {TAG_W{1'b0}};
      end
    end else if (en_s) begin
      valid_r[0] <= in_valid;
      tag_r[0]   <= tag;
      for (int i = 1; i < LAT; i++) begin
        valid_r[i] <= valid_r[i-1];
        tag_r[i]   <= tag_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[LAT-1];
  assign out_tag   = tag_r[LAT-1];
  assign busy      = |valid_r;

  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    mod_bf_lane #(
      .WIDTH (WIDTH),
      .LAT   (LAT)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (en_s),
      .mode  (mode),
      .swap  (swap),
      .a     (A[g]),
      .b     (B[g]),
      .w     (W[g]),
      .q     (modulus),
      .a_out (A_out[g]),
      .b_out (B_out[g])
    );
  end

endmodule
